host_launcher: RTL and testbench
================================

HOST_LAUNCHER -- requirements
Module: host_launcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd4096: maximum RUN cycles allowed before abort.
REQ-002 SHALL have ports (clock and reset first):
  Clk        in   1  system clock, rising edge
  Reset_n    in   1  asynchronous, active-low reset
  Go         in   1  launch a job; sampled only in IDLE
  Dump_base  in   8  first readback address; latched on accepted Go
  Dump_len   in   8  readback byte count; latched on accepted Go
  Ld_valid   in   1  load beat valid
  Ld_ready   out  1  load beat accepted
  Ld_addr    in   8  load target address
  Ld_data    in   8  load data
  Ld_last    in   1  marks final load beat
  Mem_we     out  1  data-memory write enable
  Mem_addr   out  8  data-memory address
  Mem_wdata  out  8  data-memory write data
  Mem_rdata  in   8  data-memory read data, valid 1 cycle after address
  Start      out  1  processor start/hold line
  Ack        in   1  processor done flag
  Rd_valid   out  1  readback beat valid
  Rd_ready   in   1  readback beat accepted
  Rd_addr    out  8  address of readback beat
  Rd_data    out  8  readback data
  Busy       out  1  high in every state except IDLE
  Done       out  1  one-cycle pulse at job end
  Timeout    out  1  sticky: last job aborted
  Cycles     out  16 RUN cycle count of last job

Function
REQ-003 SHALL implement states IDLE, CLEAR, LOAD, LAUNCH, RUN, DUMP, DONE.
REQ-004 IDLE: Go=1 SHALL latch Dump_base/Dump_len, clear Timeout and Cycles, and move to CLEAR.
REQ-005 CLEAR SHALL write 8'h00 to addresses 0..255, one per cycle (Mem_we=1), taking exactly 256 cycles, then enter LOAD.
REQ-006 LOAD SHALL hold Ld_ready=1; each Ld_valid&Ld_ready cycle SHALL write Ld_data to Ld_addr that same cycle; a beat with Ld_last=1 SHALL move to LAUNCH.
REQ-007 Start SHALL be 1 in CLEAR, LOAD and LAUNCH, and 0 in all other states.
REQ-008 LAUNCH SHALL last exactly 1 cycle, then enter RUN; the Start 1->0 edge therefore marks the program launch.
REQ-009 RUN SHALL increment Cycles every cycle, saturating at 16'hFFFF.
REQ-010 Ack=1 in RUN SHALL enter DUMP; Ack SHALL be ignored in every other state.
REQ-011 If Cycles reaches TIMEOUT_CYC-1 in RUN without Ack, the block SHALL set Timeout and enter DUMP.
REQ-012 Ack and timeout in the same cycle SHALL count as Ack: Timeout stays 0.
REQ-013 DUMP SHALL read addresses Dump_base .. Dump_base+Dump_len-1, wrapping modulo 256.
REQ-014 For each byte, DUMP SHALL issue Mem_addr, capture Mem_rdata one cycle later, then hold Rd_valid=1 with stable Rd_addr/Rd_data until Rd_ready=1.
REQ-015 Dump_len=0 SHALL skip DUMP: RUN goes directly to DONE.
REQ-016 DONE SHALL assert Done for exactly 1 cycle, then return to IDLE.
REQ-017 Go outside IDLE SHALL be ignored.
REQ-018 Mem_we SHALL be 0 in IDLE, LAUNCH, RUN, DUMP and DONE.
REQ-019 Ld_ready SHALL be 0 outside LOAD.
REQ-020 All outputs SHALL be registered, except Mem_we, Mem_addr, Mem_wdata and Ld_ready, which may decode from state.

Reset
REQ-021 Reset_n=0 SHALL immediately force IDLE.
REQ-022 Reset_n=0 SHALL immediately drive Start, Mem_we, Ld_ready, Rd_valid, Busy, Done and Timeout to 0, and Cycles, Mem_addr, Mem_wdata, Rd_addr and Rd_data to 0.
REQ-023 Reset in any state SHALL abandon the job with no further memory writes; memory contents are left as-is.

Structure
REQ-024 A shared package host_pkg SHALL hold the state enum, the 8-bit address/data widths, and the TIMEOUT_CYC default.
REQ-025 One sub-module, run_timer, SHALL implement the saturating 16-bit cycle counter with clear, enable and a timeout compare.

Verification
REQ-026 Go; load 3 beats ({5,8'hAA},{31,8'h11},{200,8'h7F} last); Ack 10 cycles after launch; Dump_base=30, Dump_len=2 -> readback (30,00),(31,11); Cycles=10; Timeout=0; Done pulses once.
REQ-027 Never assert Ack, TIMEOUT_CYC=16 -> Timeout=1, Cycles=15, DUMP still executes, then Done.
REQ-028 Dump_base=255, Dump_len=2 -> readback addresses 255 then 0.
REQ-029 Hold Rd_ready=0 for 5 cycles on the first beat -> Rd_valid/Rd_data stay stable; no beat is lost or duplicated.
REQ-030 Pulse Reset_n low during LOAD -> IDLE, Start=0, Busy=0 at once; a following Go completes normally.
REQ-031 Ack asserted during LOAD, Dump_len=0 -> Ack is ignored; RUN waits for a fresh Ack, then goes straight to DONE.

Source files
------------

// File: rtl/host_pkg.sv
// Shared types and constants for the host launcher.
// Job states, widths and the default RUN watchdog.
package host_pkg;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam logic [CW-1:0] TIMEOUT_DEF = 16'd4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    D_ISSUE,
    D_CAP,
    D_HOLD
  } dph_t;

endpackage

// File: rtl/run_timer.sv
// Saturating RUN-cycle counter with clear, enable
// and a compare that fires on the cycle reaching limit-1.
module run_timer
  import host_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] q,
  output logic          hit
);

  logic [CW-1:0] nxt;

  assign nxt = (q == '1) ? q : q + 1'b1;
  assign hit = en && (nxt == limit - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/host_launcher.sv
// Host-side job sequencer: clear and load data memory,
// launch the core, watch for done/timeout, read back.
module host_launcher
  import host_pkg::*;
#(
  parameter logic [CW-1:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Go,
  input  logic [AW-1:0] Dump_base,
  input  logic [AW-1:0] Dump_len,
  input  logic          Ld_valid,
  output logic          Ld_ready,
  input  logic [AW-1:0] Ld_addr,
  input  logic [DW-1:0] Ld_data,
  input  logic          Ld_last,
  output logic          Mem_we,
  output logic [AW-1:0] Mem_addr,
  output logic [DW-1:0] Mem_wdata,
  input  logic [DW-1:0] Mem_rdata,
  output logic          Start,
  input  logic          Ack,
  output logic          Rd_valid,
  input  logic          Rd_ready,
  output logic [AW-1:0] Rd_addr,
  output logic [DW-1:0] Rd_data,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [CW-1:0] Cycles
);

  state_t        st, st_nx;
  dph_t          ph;
  logic [AW-1:0] ctr;
  logic [AW-1:0] base_q;
  logic [AW-1:0] rem;
  logic          run, tmr_clr, tmr_hit, fin;

  assign run     = (st == S_RUN);
  assign tmr_clr = (st == S_IDLE) && Go;
  assign fin     = run && (Ack || tmr_hit);

  run_timer u_tmr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (tmr_clr),
    .en    (run),
    .limit (TIMEOUT_CYC),
    .q     (Cycles),
    .hit   (tmr_hit)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:   if (Go) st_nx = S_CLEAR;
      S_CLEAR:  if (ctr == '1) st_nx = S_LOAD;
      S_LOAD:   if (Ld_valid && Ld_last) st_nx = S_LAUNCH;
      S_LAUNCH: st_nx = S_RUN;
      S_RUN:
        if (fin) st_nx = (rem == '0) ? S_DONE : S_DUMP;
      S_DUMP:
        if (ph == D_HOLD && Rd_ready && rem == 8'd1)
          st_nx = S_DONE;
      S_DONE:   st_nx = S_IDLE;
      default:  st_nx = S_IDLE;
    endcase
  end

  // memory port is a pure decode of state so reset silences it at once
  always_comb begin
    Ld_ready  = (st == S_LOAD);
    Mem_we    = 1'b0;
    Mem_addr  = '0;
    Mem_wdata = '0;
    unique case (1'b1)
      st == S_CLEAR: begin
        Mem_we   = 1'b1;
        Mem_addr = ctr;
      end
      st == S_LOAD: begin
        Mem_we    = Ld_valid;
        Mem_addr  = Ld_addr;
        Mem_wdata = Ld_data;
      end
      st == S_DUMP: Mem_addr = ctr;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st       <= S_IDLE;
      ph       <= D_ISSUE;
      ctr      <= '0;
      base_q   <= '0;
      rem      <= '0;
      Start    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Timeout  <= 1'b0;
      Rd_valid <= 1'b0;
      Rd_addr  <= '0;
      Rd_data  <= '0;
    end else begin
      st    <= st_nx;
      Start <= st_nx inside {S_CLEAR, S_LOAD, S_LAUNCH};
      Busy  <= (st_nx != S_IDLE);
      Done  <= (st_nx == S_DONE);
      unique case (st)
        S_IDLE: if (Go) begin
          base_q  <= Dump_base;
          rem     <= Dump_len;
          ctr     <= '0;
          Timeout <= 1'b0;
        end
        S_CLEAR: ctr <= ctr + 1'b1;
        S_RUN: if (fin) begin
          Timeout <= !Ack;
          ctr     <= base_q;
          ph      <= D_ISSUE;
        end
        // one byte: address, capture a cycle later, then hold
        S_DUMP: unique case (ph)
          D_ISSUE: ph <= D_CAP;
          D_CAP: begin
            Rd_valid <= 1'b1;
            Rd_addr  <= ctr;
            Rd_data  <= Mem_rdata;
            ph       <= D_HOLD;
          end
          D_HOLD: if (Rd_ready) begin
            Rd_valid <= 1'b0;
            ctr      <= ctr + 1'b1;
            rem      <= rem - 1'b1;
            ph       <= D_ISSUE;
          end
          default: ph <= D_ISSUE;
        endcase
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_launcher.sv
// Scoreboard bench for host_launcher with a small
// synchronous data-memory model and a stalling readback sink.
module tb_host_launcher;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Go;
  logic [7:0]  Dump_base, Dump_len;
  logic        Ld_valid, Ld_ready;
  logic [7:0]  Ld_addr, Ld_data;
  logic        Ld_last;
  logic        Mem_we;
  logic [7:0]  Mem_addr, Mem_wdata;
  logic [7:0]  Mem_rdata;
  logic        Start, Ack;
  logic        Rd_valid;
  logic        Rd_ready = 1'b0;
  logic [7:0]  Rd_addr, Rd_data;
  logic        Busy, Done, Timeout;
  logic [15:0] Cycles;

  host_launcher #(.TIMEOUT_CYC(16'd16)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Go        (Go),
    .Dump_base (Dump_base),
    .Dump_len  (Dump_len),
    .Ld_valid  (Ld_valid),
    .Ld_ready  (Ld_ready),
    .Ld_addr   (Ld_addr),
    .Ld_data   (Ld_data),
    .Ld_last   (Ld_last),
    .Mem_we    (Mem_we),
    .Mem_addr  (Mem_addr),
    .Mem_wdata (Mem_wdata),
    .Mem_rdata (Mem_rdata),
    .Start     (Start),
    .Ack       (Ack),
    .Rd_valid  (Rd_valid),
    .Rd_ready  (Rd_ready),
    .Rd_addr   (Rd_addr),
    .Rd_data   (Rd_data),
    .Busy      (Busy),
    .Done      (Done),
    .Timeout   (Timeout),
    .Cycles    (Cycles)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [256];
  always @(posedge Clk) begin
    if (Mem_we) mem[Mem_addr] <= Mem_wdata;
    Mem_rdata <= mem[Mem_addr];
  end

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          stall_n = 0;
  int          st_cnt = 0;
  logic [7:0]  ha, hd;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_mem [256];
  logic [7:0]  ld_a [$];
  logic [7:0]  ld_d [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // readback sink: optional stall per beat, scoreboard pop on accept
  always @(negedge Clk) begin
    logic [15:0] e;
    if (Done) done_cnt++;
    if (Rd_valid) begin
      if (st_cnt < stall_n) begin
        Rd_ready = 1'b0;
        if (st_cnt == 0) begin
          ha = Rd_addr;
          hd = Rd_data;
        end else begin
          chk("hold_addr", 32'(Rd_addr), 32'(ha));
          chk("hold_data", 32'(Rd_data), 32'(hd));
        end
        st_cnt++;
      end else begin
        Rd_ready = 1'b1;
        st_cnt = 0;
        chk("rd_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rd_addr", 32'(Rd_addr), 32'(e[15:8]));
          chk("rd_data", 32'(Rd_data), 32'(e[7:0]));
        end
      end
    end else begin
      Rd_ready = 1'b0;
    end
  end

  task automatic run_job(input string tag, input logic [7:0] base,
                         input logic [7:0] len, input int ack_at,
                         input bit ack_load, input logic exp_to,
                         input logic [15:0] exp_cyc);
    int n;
    int d0;
    logic [7:0] a;
    d0 = done_cnt;
    Dump_base = base;
    Dump_len = len;
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    n = 0;
    while (!Ld_ready && n < 1000) begin
      n++;
      @(negedge Clk);
    end
    chk({tag, "_clear_len"}, 32'(n), 32'd256);
    foreach (exp_mem[i]) exp_mem[i] = 8'h00;
    Ack = ack_load;
    foreach (ld_a[i]) begin
      Ld_valid = 1'b1;
      Ld_addr = ld_a[i];
      Ld_data = ld_d[i];
      Ld_last = (i == ld_a.size() - 1);
      exp_mem[ld_a[i]] = ld_d[i];
      @(negedge Clk);
    end
    Ld_valid = 1'b0;
    Ld_last = 1'b0;
    Ack = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 8'(i);
      exp_q.push_back({a, exp_mem[a]});
    end
    chk({tag, "_launch_start"}, 32'(Start), 32'd1);
    chk({tag, "_launch_we"}, 32'(Mem_we), 32'd0);
    @(negedge Clk);
    chk({tag, "_run_start"}, 32'(Start), 32'd0);
    Go = 1'b1;
    Ack = (ack_at == 1);
    @(negedge Clk);
    Go = 1'b0;
    Ack = 1'b0;
    chk({tag, "_go_ignored"}, 32'(Start), 32'd0);
    for (int c = 2; c <= ack_at; c++) begin
      Ack = (c == ack_at);
      @(negedge Clk);
      Ack = 1'b0;
    end
    n = 0;
    while (!Done && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_cycles"}, 32'(Cycles), 32'(exp_cyc));
    chk({tag, "_timeout"}, 32'(Timeout), 32'(exp_to));
    @(negedge Clk);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rd_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    Reset_n = 1'b0;
    Go = 1'b0;
    Dump_base = '0;
    Dump_len = '0;
    Ld_valid = 1'b0;
    Ld_addr = '0;
    Ld_data = '0;
    Ld_last = 1'b0;
    Ack = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_timeout", 32'(Timeout), 32'd0);
    chk("rst_cycles", 32'(Cycles), 32'd0);
    chk("rst_rd_valid", 32'(Rd_valid), 32'd0);
    chk("rst_we", 32'(Mem_we), 32'd0);
    chk("rst_ld_ready", 32'(Ld_ready), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    ld_a = '{8'd5, 8'd31, 8'd200};
    ld_d = '{8'hAA, 8'h11, 8'h7F};
    run_job("basic", 8'd30, 8'd2, 10, 1'b0, 1'b0, 16'd10);

    ld_a = '{8'd6};
    ld_d = '{8'h3C};
    run_job("tmo", 8'd5, 8'd2, 0, 1'b0, 1'b1, 16'd15);

    stall_n = 5;
    ld_a = '{8'd255, 8'd0};
    ld_d = '{8'h5A, 8'hC3};
    run_job("wrap", 8'd255, 8'd2, 4, 1'b0, 1'b0, 16'd4);
    stall_n = 0;

    Dump_base = 8'd0;
    Dump_len = 8'd1;
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    n = 0;
    while (!Ld_ready && n < 1000) begin
      n++;
      @(negedge Clk);
    end
    chk("rstld_reach_load", 32'(Ld_ready), 32'd1);
    Ld_valid = 1'b1;
    Ld_addr = 8'd10;
    Ld_data = 8'h99;
    @(negedge Clk);
    Ld_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rstld_start", 32'(Start), 32'd0);
    chk("rstld_busy", 32'(Busy), 32'd0);
    chk("rstld_ld_ready", 32'(Ld_ready), 32'd0);
    chk("rstld_we", 32'(Mem_we), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    ld_a = '{8'd11};
    ld_d = '{8'h01};
    run_job("after_rst", 8'd10, 8'd2, 3, 1'b0, 1'b0, 16'd3);

    ld_a = '{8'd40, 8'd41};
    ld_d = '{8'h12, 8'h34};
    run_job("ack_load", 8'd40, 8'd0, 5, 1'b1, 1'b0, 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1);
  end

endmodule
